// File: rtl/m68k_bus_target_pkg.sv
// ---------------------------------------------------------------------------
// m68k_bus_target_pkg
//
// Shared definitions for the 68000 bus-target slice of the PiStorm16 top
// level: the target state encodings, the default decode window base and the
// width of the optional bus-error timeout counter. Every other file of the
// slice imports this package.
//
// Ports: none (package).
// Configuration macro: none here; the timeout feature is selected in
// m68k_bus_target.sv by TARGET_BERR_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package m68k_bus_target_pkg;

    // States of the target sequencer, from waiting for a strobe through to
    // actively negating the termination signal.
    typedef enum logic [2:0] {
        TGT_IDLE    = 3'd0,
        TGT_IGNORE  = 3'd1,
        TGT_WAIT_DS = 3'd2,
        TGT_REQUEST = 3'd3,
        TGT_ACK     = 3'd4,
        TGT_RELEASE = 3'd5,
        TGT_BERR    = 3'd6
    } tgtState_t;

    // Default window base: the 64 KiB block starting at 0xEA0000.
    localparam logic [23:0] TGT_DEFAULT_BASE_ADDR = 24'hEA0000;

    // The bus-error timeout counter is 8 bits wide.
    localparam int TGT_TIMEOUT_WIDTH   = 8;
    localparam int TGT_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/m68k_bus_target_sync2.sv
// ---------------------------------------------------------------------------
// m68k_bus_target_sync2
//
// Generic two-flop synchronizer used to bring the raw 68000 bus strobes into
// the SYSCLK domain. Both flops carry the async_reg attribute so placement
// keeps them adjacent.
//
// Ports:
//   clk_i     system clock
//   nReset_i  synchronous active-low reset, loads RESET_VAL into both stages
//   d_i       raw asynchronous input
//   q_o       synchronized output
// ---------------------------------------------------------------------------
module m68k_bus_target_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic nReset_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    // Two back-to-back flops; the strobes idle high, so resetting to the
    // negated level keeps the sequencer from seeing a phantom cycle.
    always_ff @(posedge clk_i) begin
        if (!nReset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_target.sv
// ---------------------------------------------------------------------------
// m68k_bus_target
//
// Responder side of the 68000 asynchronous bus. Cycles run by another master
// into the window [BASE_ADDR, BASE_ADDR + 2^WINDOW_BITS) are forwarded to the
// Pi-facing backend over a valid/ack handshake and terminated with nDTACK
// (or nBERR when the backend does not answer in time).
//
// Ports:
//   SYSCLK, nRESET          system clock, synchronous active-low reset
//   ENABLE                  respond only when 1 (PiStorm is not bus master)
//   A_IN[23:1], D_IN        raw address and data bus
//   nAS_IN, nUDS_IN,
//   nLDS_IN, RnW_IN         raw bus strobes (synchronized here)
//   D_OUT, D_OE             read data and per-bit output enable
//   nDTACK_OUT, nDTACK_OE   transfer acknowledge pin drive
//   nBERR_OUT, nBERR_OE     bus error pin drive (timeout feature only)
//   REQ_*                   registered backend request, held while REQ_VALID
//   REQ_ACK, RESP_RDATA     backend completion and read data
//
// Configuration: define TARGET_BERR_TIMEOUT_EN to enable the bus-error
// timeout; without it REQUEST waits indefinitely and nBERR is never driven.
// ---------------------------------------------------------------------------
module m68k_bus_target
    import m68k_bus_target_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = TGT_DEFAULT_BASE_ADDR,
    parameter int          WINDOW_BITS = 16,
    parameter int          TIMEOUT     = TGT_DEFAULT_TIMEOUT
) (
    input  logic                   SYSCLK,
    input  logic                   nRESET,
    input  logic                   ENABLE,
    input  logic [23:1]            A_IN,
    input  logic [15:0]            D_IN,
    input  logic                   nAS_IN,
    input  logic                   nUDS_IN,
    input  logic                   nLDS_IN,
    input  logic                   RnW_IN,
    output logic [15:0]            D_OUT,
    output logic [15:0]            D_OE,
    output logic                   nDTACK_OUT,
    output logic                   nDTACK_OE,
    output logic                   nBERR_OUT,
    output logic                   nBERR_OE,
    output logic                   REQ_VALID,
    output logic [WINDOW_BITS-2:0] REQ_ADDR,
    output logic                   REQ_READ,
    output logic [1:0]             REQ_BE,
    output logic [15:0]            REQ_WDATA,
    input  logic                   REQ_ACK,
    input  logic [15:0]            RESP_RDATA
);

    // Parameter sanity: the window must be aligned and TIMEOUT must fit the
    // counter, otherwise the decode or the timeout compare would be wrong.
    if ((BASE_ADDR & ((24'd1 << WINDOW_BITS) - 24'd1)) != 24'd0 ||
        TIMEOUT < 1 || TIMEOUT >= (1 << TGT_TIMEOUT_WIDTH)) begin : g_badParams
        $error("m68k_bus_target: BASE_ADDR not window-aligned or TIMEOUT out of range");
    end

    logic nAsS;
    logic nUdsS;
    logic nLdsS;
    logic rnwS;

    m68k_bus_target_sync2 #(.RESET_VAL(1'b1)) u_syncAs (
        .clk_i(SYSCLK), .nReset_i(nRESET), .d_i(nAS_IN), .q_o(nAsS)
    );
    m68k_bus_target_sync2 #(.RESET_VAL(1'b1)) u_syncUds (
        .clk_i(SYSCLK), .nReset_i(nRESET), .d_i(nUDS_IN), .q_o(nUdsS)
    );
    m68k_bus_target_sync2 #(.RESET_VAL(1'b1)) u_syncLds (
        .clk_i(SYSCLK), .nReset_i(nRESET), .d_i(nLDS_IN), .q_o(nLdsS)
    );
    m68k_bus_target_sync2 #(.RESET_VAL(1'b1)) u_syncRnw (
        .clk_i(SYSCLK), .nReset_i(nRESET), .d_i(RnW_IN), .q_o(rnwS)
    );

    tgtState_t              state_q,     state_d;
    logic [WINDOW_BITS-2:0] reqAddr_q,   reqAddr_d;
    logic                   reqRead_q,   reqRead_d;
    logic [1:0]             reqBe_q,     reqBe_d;
    logic [15:0]            reqWdata_q,  reqWdata_d;
    logic                   reqValid_q,  reqValid_d;
    logic                   dsSeen_q,    dsSeen_d;
    logic [15:0]            dOut_q,      dOut_d;
    logic                   dOe_q,       dOe_d;
    logic                   nDtackOe_q,  nDtackOe_d;
    logic                   nDtackOut_q, nDtackOut_d;

`ifdef TARGET_BERR_TIMEOUT_EN
    localparam logic [TGT_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TGT_TIMEOUT_WIDTH'(TIMEOUT - 1);

    logic [TGT_TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                         relBerr_q,  relBerr_d;
    logic                         nBerrOe_q,  nBerrOe_d;
    logic                         nBerrOut_q, nBerrOut_d;
`endif

    // Next-state logic. A new cycle is only accepted while no request is
    // pending, so a request left over from an aborted cycle keeps REQ_*
    // stable until the backend finally acks it (that ack is dropped).
    // Pin drives are decoded from the next state so they leave a flop.
    always_comb begin
        state_d     = state_q;
        reqAddr_d   = reqAddr_q;
        reqRead_d   = reqRead_q;
        reqBe_d     = reqBe_q;
        reqWdata_d  = reqWdata_q;
        reqValid_d  = reqValid_q;
        dsSeen_d    = dsSeen_q;
        dOut_d      = dOut_q;
        dOe_d       = 1'b0;
        nDtackOe_d  = 1'b0;
        nDtackOut_d = 1'b1;
`ifdef TARGET_BERR_TIMEOUT_EN
        cnt_d       = cnt_q;
        relBerr_d   = relBerr_q;
        nBerrOe_d   = 1'b0;
        nBerrOut_d  = 1'b1;
`endif

        if (reqValid_q && REQ_ACK) begin
            reqValid_d = 1'b0;
        end

        case (state_q)
            TGT_IDLE: begin
                dsSeen_d = 1'b0;
`ifdef TARGET_BERR_TIMEOUT_EN
                relBerr_d = 1'b0;
`endif
                if (!nAsS && ENABLE && !reqValid_q) begin
                    if (A_IN[23:WINDOW_BITS] != BASE_ADDR[23:WINDOW_BITS]) begin
                        state_d = TGT_IGNORE;
                    end else begin
                        reqAddr_d = A_IN[WINDOW_BITS-1:1];
                        reqRead_d = rnwS;
                        state_d   = TGT_WAIT_DS;
                    end
                end
            end

            TGT_IGNORE: begin
                if (nAsS) begin
                    state_d = TGT_IDLE;
                end
            end

            // Reads issue as soon as a data strobe is seen; writes wait one
            // more cycle so D_IN has settled as long as the strobes have.
            TGT_WAIT_DS: begin
                if (nAsS) begin
                    state_d = TGT_RELEASE;
                end else if (!dsSeen_q) begin
                    if (!nUdsS || !nLdsS) begin
                        reqBe_d = ~{nUdsS, nLdsS};
                        if (reqRead_q) begin
                            reqValid_d = 1'b1;
                            state_d    = TGT_REQUEST;
`ifdef TARGET_BERR_TIMEOUT_EN
                            cnt_d      = '0;
`endif
                        end else begin
                            dsSeen_d = 1'b1;
                        end
                    end
                end else begin
                    reqWdata_d = D_IN;
                    reqValid_d = 1'b1;
                    state_d    = TGT_REQUEST;
`ifdef TARGET_BERR_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end

            TGT_REQUEST: begin
                if (reqValid_q && REQ_ACK) begin
                    if (reqRead_q) begin
                        dOut_d = RESP_RDATA;
                    end
                    state_d = TGT_ACK;
                end else if (nAsS) begin
                    state_d = TGT_RELEASE;
`ifdef TARGET_BERR_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = TGT_BERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            TGT_ACK: begin
                if (nAsS) begin
                    state_d = TGT_RELEASE;
                end
            end

            TGT_BERR: begin
                if (nAsS) begin
                    state_d = TGT_RELEASE;
`ifdef TARGET_BERR_TIMEOUT_EN
                    relBerr_d = 1'b1;
`endif
                end
            end

            TGT_RELEASE: begin
                state_d = TGT_IDLE;
            end

            default: begin
                state_d = TGT_IDLE;
            end
        endcase

        // RELEASE actively negates whichever signal terminated the cycle;
        // after a bus error nDTACK stays untouched.
        dOe_d = (state_d == TGT_ACK) && reqRead_d;
`ifdef TARGET_BERR_TIMEOUT_EN
        nDtackOe_d  = (state_d == TGT_ACK) || (state_d == TGT_RELEASE && !relBerr_d);
        nBerrOe_d   = (state_d == TGT_BERR) || (state_d == TGT_RELEASE && relBerr_d);
        nBerrOut_d  = (state_d != TGT_BERR);
`else
        nDtackOe_d  = (state_d == TGT_ACK) || (state_d == TGT_RELEASE);
`endif
        nDtackOut_d = (state_d != TGT_ACK);
    end

    // State, request and pin-drive registers. Reset is honoured at any point
    // of a bus cycle and leaves every pin released.
    always_ff @(posedge SYSCLK) begin
        if (!nRESET) begin
            state_q     <= TGT_IDLE;
            reqAddr_q   <= '0;
            reqRead_q   <= 1'b0;
            reqBe_q     <= 2'b00;
            reqWdata_q  <= 16'h0000;
            reqValid_q  <= 1'b0;
            dsSeen_q    <= 1'b0;
            dOut_q      <= 16'h0000;
            dOe_q       <= 1'b0;
            nDtackOe_q  <= 1'b0;
            nDtackOut_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            reqRead_q   <= reqRead_d;
            reqBe_q     <= reqBe_d;
            reqWdata_q  <= reqWdata_d;
            reqValid_q  <= reqValid_d;
            dsSeen_q    <= dsSeen_d;
            dOut_q      <= dOut_d;
            dOe_q       <= dOe_d;
            nDtackOe_q  <= nDtackOe_d;
            nDtackOut_q <= nDtackOut_d;
        end
    end

`ifdef TARGET_BERR_TIMEOUT_EN
    // Timeout counter and bus-error drive registers.
    always_ff @(posedge SYSCLK) begin
        if (!nRESET) begin
            cnt_q      <= '0;
            relBerr_q  <= 1'b0;
            nBerrOe_q  <= 1'b0;
            nBerrOut_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            relBerr_q  <= relBerr_d;
            nBerrOe_q  <= nBerrOe_d;
            nBerrOut_q <= nBerrOut_d;
        end
    end

    assign nBERR_OE  = nBerrOe_q;
    assign nBERR_OUT = nBerrOut_q;
`else
    assign nBERR_OE  = 1'b0;
    assign nBERR_OUT = 1'b1;
`endif

    assign D_OUT      = dOut_q;
    assign D_OE       = {16{dOe_q}};
    assign nDTACK_OE  = nDtackOe_q;
    assign nDTACK_OUT = nDtackOut_q;
    assign REQ_VALID  = reqValid_q;
    assign REQ_ADDR   = reqAddr_q;
    assign REQ_READ   = reqRead_q;
    assign REQ_BE     = reqBe_q;
    assign REQ_WDATA  = reqWdata_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_target
//
// Directed bench for m68k_bus_target with default parameters. It plays the
// part of the foreign bus master and of the backend. Honours
// TARGET_BERR_TIMEOUT_EN for the timeout scenario.
// ---------------------------------------------------------------------------
module tb_m68k_bus_target;
    import m68k_bus_target_pkg::*;

    logic        SYSCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        ENABLE = 1'b1;
    logic [23:1] A_IN = '0;
    logic [15:0] D_IN = 16'h0000;
    logic        nAS_IN = 1'b1;
    logic        nUDS_IN = 1'b1;
    logic        nLDS_IN = 1'b1;
    logic        RnW_IN = 1'b1;
    logic [15:0] D_OUT;
    logic [15:0] D_OE;
    logic        nDTACK_OUT;
    logic        nDTACK_OE;
    logic        nBERR_OUT;
    logic        nBERR_OE;
    logic        REQ_VALID;
    logic [14:0] REQ_ADDR;
    logic        REQ_READ;
    logic [1:0]  REQ_BE;
    logic [15:0] REQ_WDATA;
    logic        REQ_ACK = 1'b0;
    logic [15:0] RESP_RDATA = 16'h0000;

    int assertCount = 0;
    int failCount   = 0;

    logic sawValid;
    logic sawDoe;
    logic sawDtackOe;
    logic sawBerrOe;

    m68k_bus_target dut (
        .SYSCLK(SYSCLK), .nRESET(nRESET), .ENABLE(ENABLE),
        .A_IN(A_IN), .D_IN(D_IN),
        .nAS_IN(nAS_IN), .nUDS_IN(nUDS_IN), .nLDS_IN(nLDS_IN), .RnW_IN(RnW_IN),
        .D_OUT(D_OUT), .D_OE(D_OE),
        .nDTACK_OUT(nDTACK_OUT), .nDTACK_OE(nDTACK_OE),
        .nBERR_OUT(nBERR_OUT), .nBERR_OE(nBERR_OE),
        .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_READ(REQ_READ),
        .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
        .REQ_ACK(REQ_ACK), .RESP_RDATA(RESP_RDATA)
    );

    // 8 ns SYSCLK, inside the PLL range.
    always #4 SYSCLK = ~SYSCLK;

    // Sticky observers for properties that must hold over a whole bus cycle.
    always @(negedge SYSCLK) begin
        if (REQ_VALID)  sawValid   = 1'b1;
        if (|D_OE)      sawDoe     = 1'b1;
        if (nDTACK_OE)  sawDtackOe = 1'b1;
        if (nBERR_OE)   sawBerrOe  = 1'b1;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearFlags();
        sawValid   = 1'b0;
        sawDoe     = 1'b0;
        sawDtackOe = 1'b0;
        sawBerrOe  = 1'b0;
    endtask

    // Start a cycle with nAS and the data strobes falling together.
    task automatic applyStimulus(input logic [23:0] addr, input logic rnw,
                                 input logic [1:0] be, input logic [15:0] wdata);
        @(negedge SYSCLK);
        A_IN    = addr[23:1];
        RnW_IN  = rnw;
        D_IN    = wdata;
        nAS_IN  = 1'b0;
        nUDS_IN = ~be[1];
        nLDS_IN = ~be[0];
    endtask

    task automatic endCycle();
        nAS_IN  = 1'b1;
        nUDS_IN = 1'b1;
        nLDS_IN = 1'b1;
        RnW_IN  = 1'b1;
    endtask

    task automatic waitReqValid(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge SYSCLK);
            cycles++;
        end while (!REQ_VALID && cycles < 20);
        if (!REQ_VALID) checkOutput({tag, "_validTimeout"}, 32'(REQ_VALID), 32'd1);
    endtask

    // Full word read with the backend acking ackDelay cycles after REQ_VALID.
    task automatic readCycle(input string tag, input logic [23:0] addr,
                             input logic [15:0] rdata, input int ackDelay);
        int          cycles;
        logic [14:0] expAddr;
        expAddr = addr[15:1];
        applyStimulus(addr, 1'b1, 2'b11, 16'h0000);
        waitReqValid(tag, cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd4);
        checkOutput({tag, "_addr"}, 32'(REQ_ADDR), 32'(expAddr));
        checkOutput({tag, "_be"}, 32'(REQ_BE), 32'd3);
        checkOutput({tag, "_read"}, 32'(REQ_READ), 32'd1);
        repeat (ackDelay) @(negedge SYSCLK);
        REQ_ACK    = 1'b1;
        RESP_RDATA = rdata;
        @(negedge SYSCLK);
        REQ_ACK = 1'b0;
        checkOutput({tag, "_dtackOe"}, 32'(nDTACK_OE), 32'd1);
        checkOutput({tag, "_dtackLow"}, 32'(nDTACK_OUT), 32'd0);
        checkOutput({tag, "_dOe"}, 32'(D_OE), 32'hFFFF);
        checkOutput({tag, "_dOut"}, 32'(D_OUT), 32'(rdata));
        checkOutput({tag, "_validDrop"}, 32'(REQ_VALID), 32'd0);
        repeat (2) @(negedge SYSCLK);
        endCycle();
        repeat (3) @(negedge SYSCLK);
        checkOutput({tag, "_relDtackOe"}, 32'(nDTACK_OE), 32'd1);
        checkOutput({tag, "_relDtackHigh"}, 32'(nDTACK_OUT), 32'd1);
        checkOutput({tag, "_relDoe"}, 32'(D_OE), 32'h0000);
        @(negedge SYSCLK);
        checkOutput({tag, "_dtackOff"}, 32'(nDTACK_OE), 32'd0);
        @(negedge SYSCLK);
        checkOutput({tag, "_allOff"}, 32'({D_OE, nDTACK_OE, nBERR_OE}), 32'd0);
    endtask

    initial begin
        int          cycles;
        logic [23:0] addr;

        clearFlags();

        // Reset state.
        repeat (4) @(negedge SYSCLK);
        checkOutput("rst_dtackOe", 32'(nDTACK_OE), 32'd0);
        checkOutput("rst_dtackOut", 32'(nDTACK_OUT), 32'd1);
        checkOutput("rst_berr", 32'({nBERR_OE, nBERR_OUT}), 32'd1);
        checkOutput("rst_d", 32'({D_OE, D_OUT}), 32'd0);
        checkOutput("rst_req", 32'({REQ_VALID, REQ_ADDR, REQ_READ, REQ_BE, REQ_WDATA}), 32'd0);
        nRESET = 1'b1;
        repeat (3) @(negedge SYSCLK);

        // Word read at 0xEA0010, backend acks two cycles after REQ_VALID.
        readCycle("t1", 24'hEA0010, 16'hBEEF, 2);
        repeat (4) @(negedge SYSCLK);

        // Byte write at 0xEA0003 on the low lane, DS two cycles after AS.
        clearFlags();
        addr = 24'hEA0003;
        @(negedge SYSCLK);
        A_IN   = addr[23:1];
        RnW_IN = 1'b0;
        D_IN   = 16'h0055;
        nAS_IN = 1'b0;
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        nLDS_IN = 1'b0;
        waitReqValid("t2", cycles);
        checkOutput("t2_latency", 32'(cycles), 32'd4);
        checkOutput("t2_addr", 32'(REQ_ADDR), 32'h0001);
        checkOutput("t2_be", 32'(REQ_BE), 32'd1);
        checkOutput("t2_wdata", 32'(REQ_WDATA), 32'h0055);
        checkOutput("t2_read", 32'(REQ_READ), 32'd0);
        REQ_ACK = 1'b1;
        @(negedge SYSCLK);
        REQ_ACK = 1'b0;
        checkOutput("t2_dtack", 32'({nDTACK_OE, nDTACK_OUT}), 32'b10);
        repeat (2) @(negedge SYSCLK);
        endCycle();
        repeat (6) @(negedge SYSCLK);
        checkOutput("t2_neverDoe", 32'(sawDoe), 32'd0);
        checkOutput("t2_dtackOff", 32'(nDTACK_OE), 32'd0);

        // Read outside the window: nothing driven, no request.
        clearFlags();
        applyStimulus(24'hDA0000, 1'b1, 2'b11, 16'h0000);
        repeat (10) @(negedge SYSCLK);
        endCycle();
        repeat (6) @(negedge SYSCLK);
        checkOutput("t3_outside", 32'({sawValid, sawDoe, sawDtackOe, sawBerrOe}), 32'd0);

        // Inside the window but disabled: same result.
        clearFlags();
        ENABLE = 1'b0;
        applyStimulus(24'hEA0000, 1'b1, 2'b11, 16'h0000);
        repeat (10) @(negedge SYSCLK);
        endCycle();
        repeat (6) @(negedge SYSCLK);
        checkOutput("t3_disabled", 32'({sawValid, sawDoe, sawDtackOe, sawBerrOe}), 32'd0);
        ENABLE = 1'b1;
        repeat (2) @(negedge SYSCLK);

        // Backend never answers.
        clearFlags();
        applyStimulus(24'hEA0020, 1'b1, 2'b11, 16'h0000);
        waitReqValid("t4", cycles);
`ifdef TARGET_BERR_TIMEOUT_EN
        cycles = 0;
        do begin
            @(negedge SYSCLK);
            cycles++;
        end while (!nBERR_OE && cycles < 300);
        checkOutput("t4_berrDelay", 32'(cycles), 32'd255);
        checkOutput("t4_berrLow", 32'(nBERR_OUT), 32'd0);
        checkOutput("t4_validHeld", 32'(REQ_VALID), 32'd1);
        endCycle();
        repeat (3) @(negedge SYSCLK);
        checkOutput("t4_berrNegate", 32'({nBERR_OE, nBERR_OUT}), 32'b11);
        @(negedge SYSCLK);
        checkOutput("t4_berrOff", 32'(nBERR_OE), 32'd0);
        checkOutput("t4_noDtack", 32'(sawDtackOe), 32'd0);
`else
        repeat (300) @(negedge SYSCLK);
        checkOutput("t4_noBerr", 32'(sawBerrOe), 32'd0);
        checkOutput("t4_noDtack", 32'(sawDtackOe), 32'd0);
        checkOutput("t4_validHeld", 32'(REQ_VALID), 32'd1);
        endCycle();
        repeat (6) @(negedge SYSCLK);
        checkOutput("t4_abortOff", 32'({D_OE, nDTACK_OE}), 32'd0);
`endif
        REQ_ACK = 1'b1;
        @(negedge SYSCLK);
        REQ_ACK = 1'b0;
        @(negedge SYSCLK);
        checkOutput("t4_lateAckDrop", 32'(REQ_VALID), 32'd0);
        repeat (2) @(negedge SYSCLK);

        // Reset while in ACK, then a normal cycle.
        applyStimulus(24'hEA0040, 1'b1, 2'b11, 16'h0000);
        waitReqValid("t5", cycles);
        REQ_ACK    = 1'b1;
        RESP_RDATA = 16'hCAFE;
        @(negedge SYSCLK);
        REQ_ACK = 1'b0;
        checkOutput("t5_inAck", 32'({nDTACK_OE, nDTACK_OUT}), 32'b10);
        nRESET = 1'b0;
        @(negedge SYSCLK);
        checkOutput("t5_rstOe", 32'({D_OE, nDTACK_OE, nBERR_OE}), 32'd0);
        checkOutput("t5_rstDtack", 32'(nDTACK_OUT), 32'd1);
        checkOutput("t5_rstValid", 32'(REQ_VALID), 32'd0);
        checkOutput("t5_rstState", 32'(dut.state_q), 32'(TGT_IDLE));
        endCycle();
        repeat (3) @(negedge SYSCLK);
        nRESET = 1'b1;
        repeat (4) @(negedge SYSCLK);
        readCycle("t5b", 24'hEA0044, 16'h1234, 1);

        // Back-to-back reads with nAS high for roughly one bus clock.
        repeat (2) @(negedge SYSCLK);
        readCycle("t6a", 24'hEA0100, 16'h1111, 0);
        repeat (11) @(negedge SYSCLK);
        readCycle("t6b", 24'hEA0102, 16'h2222, 0);

        repeat (4) @(negedge SYSCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/m68k_bus_target.md
# m68k_bus_target

Responder side of the 68000 asynchronous bus: decodes cycles run by another bus master (Zorro DMA card, chipset-side initiator) into a fixed address window, forwards them to a Pi-facing backend over a valid/ack handshake, and terminates them with nDTACK (or nBERR on timeout). It sits beside the bus-master sequencer in the PiStorm16 top level. It drives the shared D/nDTACK/nBERR pins only while it owns a cycle and the PiStorm is not bus master.

## Interface
- BASE_ADDR, 24'hEA0000, window base; must be aligned to 2^WINDOW_BITS.
- WINDOW_BITS, 16, window size exponent; the window is 64 KiB.
- TIMEOUT, 255, SYSCLK cycles to wait for REQ_ACK before nBERR (8-bit counter).
- SYSCLK  in  1  system clock (PLL, 120–145 MHz).
- nRESET  in  1  synchronous, active-low reset.
- ENABLE  in  1  target responds only when 1; tie to the inverse of "PiStorm is bus master".
- A_IN  in  23  address bus [23:1], raw.
- D_IN  in  16  data bus, raw.
- nAS_IN, nUDS_IN, nLDS_IN, RnW_IN  in  1 each  bus strobes, raw/asynchronous.
- D_OUT, D_OE  out  16 each  read data and per-bit output enable.
- nDTACK_OUT, nDTACK_OE  out  1 each  transfer acknowledge.
- nBERR_OUT, nBERR_OE  out  1 each  bus error (only with the timeout feature).
- REQ_VALID  out  1  backend request pending.
- REQ_ADDR  out  WINDOW_BITS-1  word offset within the window.
- REQ_READ  out  1  1 = read.
- REQ_BE  out  2  {UDS, LDS} byte enables, active high.
- REQ_WDATA  out  16  write data.
- REQ_ACK  in  1  backend done; RESP_RDATA is valid in the same cycle.
- RESP_RDATA  in  16  read data.

## Operation
- Inputs nAS/nUDS/nLDS/RnW use 2-FF synchronizers (async_reg). A_IN and D_IN are captured unsynchronized, only once the synchronized strobes are asserted; they are stable on the bus by then.
- IDLE: wait for synced nAS=0 and ENABLE=1. Capture A_IN and RnW. If A_IN[23:WINDOW_BITS] ≠ BASE_ADDR[23:WINDOW_BITS], go to IGNORE; otherwise go to WAIT_DS.
- IGNORE: drive nothing. Return to IDLE when synced nAS=1.
- WAIT_DS: wait for either synced DS=0. Latch REQ_BE = ~{nUDS,nLDS}. For writes, latch D_IN one SYSCLK after DS is seen, which gives two sync stages of settling. Then go to REQUEST.
- REQUEST: REQ_VALID=1 with all REQ_* signals held stable. On REQ_ACK, drop REQ_VALID and latch RESP_RDATA (reads). Go to ACK.
- ACK: D_OE=all-ones for reads. nDTACK_OE=1, nDTACK_OUT=0. Hold until synced nAS=1, then go to RELEASE.
- RELEASE: one cycle with nDTACK_OUT=1 and nDTACK_OE=1 (active negation), D_OE=0. Next cycle nDTACK_OE=0, then IDLE.
- Synced nAS rising in WAIT_DS or REQUEST (aborted cycle): go to RELEASE without asserting nDTACK. If REQ_VALID is up, it stays up until REQ_ACK; the ack is discarded.
- ENABLE falling mid-cycle has no effect until IDLE.
- Reset (nRESET=0 at a SYSCLK edge): state=IDLE. Every OE=0. nDTACK_OUT=1, nBERR_OUT=1, D_OUT=0, REQ_VALID=0, REQ_*=0, timeout counter=0. Applies mid-cycle as well.

## Timing
- Latency from raw nAS/DS fall to REQ_VALID is 3–4 SYSCLK. REQ_ACK to nDTACK low is 1 SYSCLK. For reads, D_OE rises in the same cycle as nDTACK.
- With a same-cycle REQ_ACK, nDTACK falls ≤6 SYSCLK (~45 ns at 133 MHz) after DS. A standard 68000 read therefore completes without wait states.
- Raw nAS rise to all outputs tri-stated is ≤5 SYSCLK. This is well inside the 68000's next-S0 margin.
- REQ_* are registered. REQ_ACK is sampled only while REQ_VALID=1.

## Configuration
- TARGET_BERR_TIMEOUT_EN defined: an 8-bit counter runs while in REQUEST. At TIMEOUT, set nBERR_OE=1 and nBERR_OUT=0, and REQ_VALID stays up until acked. Release nBERR as for nDTACK: negate for 1 cycle, then tri-state after nAS rises.
- Undefined: no counter; REQUEST waits indefinitely; nBERR_OE and nBERR_OUT are constant 0/1.

## Structure
- Shared package/include (global.vh style) holds: the state encodings TGT_IDLE, TGT_IGNORE, TGT_WAIT_DS, TGT_REQUEST, TGT_ACK, TGT_RELEASE, TGT_BERR; the default BASE_ADDR; and the TIMEOUT width.
- Sub-module sync2 is the generic 2-FF synchronizer, instantiated for each of the four strobes.
- All other logic lives in one state-machine module.

## Test plan
- Word read at 0xEA0010 with RESP_RDATA=0xBEEF and REQ_ACK 2 cycles after REQ_VALID. Expect REQ_ADDR=0x0008, REQ_BE=2'b11, REQ_READ=1, D_OUT=0xBEEF while nDTACK=0, and all OEs low 5 cycles after nAS rises.
- Byte write at 0xEA0003 (LDS only) with D=0x0055. Expect REQ_BE=2'b01, REQ_WDATA[7:0]=0x55, REQ_READ=0, D_OE never set.
- Read at 0xDA0000: no REQ_VALID and no OE asserted for the whole cycle. Repeat inside the window with ENABLE=0: same result.
- Backend never acks, macro defined, TIMEOUT=255: nBERR low 255 cycles after REQ_VALID and nDTACK never driven. Macro undefined: nBERR_OE stays 0.
- nRESET low while in ACK: next cycle all OEs are 0, nDTACK_OUT=1, REQ_VALID=0, state is IDLE. The next valid cycle completes normally.
- Two back-to-back reads with nAS high for only 1 bus clock between them: both complete, and the second REQ_VALID follows the first RELEASE.
